// File: rtl/player_ctrl.sv
// player_ctrl: player-ship controller for the VGA playfield.
// Keeps the ship anchor position, applies clamped per-frame moves on both
// axes, and streams the ship's SPRITE_W x SPRITE_H footprint to the VGA
// plot interface one pixel per cycle in either draw or erase colour.
module player_ctrl #(
  parameter int X_WIDTH  = 8,
  parameter int Y_WIDTH  = 7,
  parameter int SPRITE_W = 2,
  parameter int SPRITE_H = 4,
  parameter int X_START  = 155,
  parameter int Y_START  = 0,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 158,
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = 116,
  parameter int STEP     = 1,
  parameter int COLOUR_W = 3,
  parameter logic [COLOUR_W-1:0] COLOUR = 3'b111
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                frame_tick,
  input  logic                move_up,
  input  logic                move_down,
  input  logic                move_left,
  input  logic                move_right,
  input  logic                draw_req,
  input  logic                erase,
  output logic                busy,
  output logic                plot,
  output logic [X_WIDTH-1:0]  x_out,
  output logic [Y_WIDTH-1:0]  y_out,
  output logic [COLOUR_W-1:0] colour_out,
  output logic                done,
  output logic [X_WIDTH-1:0]  pos_x,
  output logic [Y_WIDTH-1:0]  pos_y
);

  // Sprite column/row counters need at least one bit even for 1-pixel sprites.
  localparam int CXW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int CYW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
  localparam logic [CXW-1:0] CX_LAST = CXW'(SPRITE_W - 1);
  localparam logic [CYW-1:0] CY_LAST = CYW'(SPRITE_H - 1);

  // Limits in one-bit-wider arithmetic so clamping never sees a wrapped value.
  localparam int XW1 = X_WIDTH + 1;
  localparam int YW1 = Y_WIDTH + 1;
  localparam logic [XW1-1:0] X_LO   = XW1'(X_MIN + STEP);
  localparam logic [XW1-1:0] X_HI   = XW1'(X_MAX);
  localparam logic [XW1-1:0] X_STEP = XW1'(STEP);
  localparam logic [YW1-1:0] Y_LO   = YW1'(Y_MIN + STEP);
  localparam logic [YW1-1:0] Y_HI   = YW1'(Y_MAX);
  localparam logic [YW1-1:0] Y_STEP = YW1'(STEP);

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [X_WIDTH-1:0]    pos_x_q, pos_x_d;
  logic [Y_WIDTH-1:0]    pos_y_q, pos_y_d;
  logic [X_WIDTH-1:0]    base_x_q, base_x_d;
  logic [Y_WIDTH-1:0]    base_y_q, base_y_d;
  logic                  erase_q, erase_d;
  logic [CXW-1:0]        cx_q, cx_d;
  logic [CYW-1:0]        cy_q, cy_d;
  logic                  busy_q, busy_d;
  logic                  plot_q, plot_d;
  logic                  done_q, done_d;
  logic [X_WIDTH-1:0]    x_out_q, x_out_d;
  logic [Y_WIDTH-1:0]    y_out_q, y_out_d;
  logic [COLOUR_W-1:0]   colour_q, colour_d;
  logic [XW1-1:0]        xWide;
  logic [YW1-1:0]        yWide;
  logic                  moveEnable;

  // Clamped anchor update, only on a frame tick while no pass is running.
  always_comb begin
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    xWide      = {1'b0, pos_x_q};
    yWide      = {1'b0, pos_y_q};
    moveEnable = frame_tick && (state_q == IDLE);
    if (moveEnable) begin
      if (move_left && !move_right) begin
        pos_x_d = (xWide >= X_LO) ? (pos_x_q - X_WIDTH'(STEP)) : X_WIDTH'(X_MIN);
      end else if (move_right && !move_left) begin
        pos_x_d = ((xWide + X_STEP) <= X_HI) ? X_WIDTH'(xWide + X_STEP) : X_WIDTH'(X_MAX);
      end
      if (move_up && !move_down) begin
        pos_y_d = (yWide >= Y_LO) ? (pos_y_q - Y_WIDTH'(STEP)) : Y_WIDTH'(Y_MIN);
      end else if (move_down && !move_up) begin
        pos_y_d = ((yWide + Y_STEP) <= Y_HI) ? Y_WIDTH'(yWide + Y_STEP) : Y_WIDTH'(Y_MAX);
      end
    end
  end

  // Draw sequencer: next state plus the registered pixel stream for the next cycle.
  always_comb begin
    state_d  = state_q;
    base_x_d = base_x_q;
    base_y_d = base_y_q;
    erase_d  = erase_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    busy_d   = busy_q;
    plot_d   = 1'b0;
    done_d   = 1'b0;
    x_out_d  = x_out_q;
    y_out_d  = y_out_q;
    colour_d = colour_q;
    unique case (state_q)
      IDLE: begin
        if (draw_req) begin
          state_d  = DRAW;
          base_x_d = pos_x_q;
          base_y_d = pos_y_q;
          erase_d  = erase;
          cx_d     = '0;
          cy_d     = '0;
          busy_d   = 1'b1;
          plot_d   = 1'b1;
          x_out_d  = pos_x_q;
          y_out_d  = pos_y_q;
          colour_d = erase ? '0 : COLOUR;
        end
      end
      DRAW: begin
        if ((cx_q == CX_LAST) && (cy_q == CY_LAST)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          if (cx_q == CX_LAST) begin
            cx_d = '0;
            cy_d = cy_q + CYW'(1);
          end else begin
            cx_d = cx_q + CXW'(1);
          end
          plot_d   = 1'b1;
          x_out_d  = base_x_q + X_WIDTH'(cx_d);
          y_out_d  = base_y_q + Y_WIDTH'(cy_d);
          colour_d = erase_q ? '0 : COLOUR;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      pos_x_q  <= X_WIDTH'(X_START);
      pos_y_q  <= Y_WIDTH'(Y_START);
      base_x_q <= '0;
      base_y_q <= '0;
      erase_q  <= 1'b0;
      cx_q     <= '0;
      cy_q     <= '0;
      busy_q   <= 1'b0;
      plot_q   <= 1'b0;
      done_q   <= 1'b0;
      x_out_q  <= '0;
      y_out_q  <= '0;
      colour_q <= '0;
    end else begin
      state_q  <= state_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      base_x_q <= base_x_d;
      base_y_q <= base_y_d;
      erase_q  <= erase_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      busy_q   <= busy_d;
      plot_q   <= plot_d;
      done_q   <= done_d;
      x_out_q  <= x_out_d;
      y_out_q  <= y_out_d;
      colour_q <= colour_d;
    end
  end

  assign busy       = busy_q;
  assign plot       = plot_q;
  assign done       = done_q;
  assign x_out      = x_out_q;
  assign y_out      = y_out_q;
  assign colour_out = colour_q;
  assign pos_x      = pos_x_q;
  assign pos_y      = pos_y_q;

endmodule

// File: tb/tb_player_ctrl.sv
// tb_player_ctrl: directed and randomized checks of player_ctrl against a
// pixel-queue reference model, plus a STEP=4 instance for clamping at the limits.
module tb_player_ctrl;

  localparam int W      = 2;
  localparam int H      = 4;
  localparam int XSTART = 155;
  localparam int YSTART = 0;
  localparam int XMIN   = 0;
  localparam int XMAX   = 158;
  localparam int YMIN   = 0;
  localparam int YMAX   = 116;
  localparam int STEP   = 1;
  localparam int COL    = 7;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_tick = 1'b0, move_up = 1'b0, move_down = 1'b0;
  logic       move_left = 1'b0, move_right = 1'b0, draw_req = 1'b0, erase = 1'b0;
  logic       busy, plot, done;
  logic [7:0] x_out, pos_x;
  logic [6:0] y_out, pos_y;
  logic [2:0] colour_out;

  logic       tick2 = 1'b0, down2 = 1'b0, left2 = 1'b0;
  logic       busy2, plot2, done2;
  logic [7:0] x2, posX2;
  logic [6:0] y2, posY2;
  logic [2:0] colour2;

  int compareCount = 0;
  int failCount = 0;

  // Reference model: a queue of the per-cycle outputs still owed by a pass.
  typedef struct {
    bit plot;
    bit done;
    int x;
    int y;
    int col;
  } pix_t;
  pix_t pixQ[$];
  int   mPosX, mPosY, mX, mY, mCol;
  bit   mBusy, mPlot, mDone;

  always #5 clk = ~clk;

  player_ctrl #(
    .X_WIDTH(8), .Y_WIDTH(7), .SPRITE_W(W), .SPRITE_H(H),
    .X_START(XSTART), .Y_START(YSTART), .X_MIN(XMIN), .X_MAX(XMAX),
    .Y_MIN(YMIN), .Y_MAX(YMAX), .STEP(STEP), .COLOUR_W(3), .COLOUR(3'b111)
  ) dut (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick),
    .move_up(move_up), .move_down(move_down), .move_left(move_left),
    .move_right(move_right), .draw_req(draw_req), .erase(erase),
    .busy(busy), .plot(plot), .x_out(x_out), .y_out(y_out),
    .colour_out(colour_out), .done(done), .pos_x(pos_x), .pos_y(pos_y)
  );

  player_ctrl #(
    .X_WIDTH(8), .Y_WIDTH(7), .SPRITE_W(W), .SPRITE_H(H),
    .X_START(2), .Y_START(114), .X_MIN(0), .X_MAX(158),
    .Y_MIN(0), .Y_MAX(116), .STEP(4), .COLOUR_W(3), .COLOUR(3'b111)
  ) dutStep4 (
    .clk(clk), .reset_n(reset_n), .frame_tick(tick2),
    .move_up(1'b0), .move_down(down2), .move_left(left2),
    .move_right(1'b0), .draw_req(1'b0), .erase(1'b0),
    .busy(busy2), .plot(plot2), .x_out(x2), .y_out(y2),
    .colour_out(colour2), .done(done2), .pos_x(posX2), .pos_y(posY2)
  );

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compareCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic modelEdge(input bit rn, input bit ft, input bit mu, input bit md,
                           input bit ml, input bit mr, input bit dr, input bit er);
    pix_t e;
    bit   idle;
    if (!rn) begin
      pixQ.delete();
      mPosX = XSTART; mPosY = YSTART;
      mBusy = 0; mPlot = 0; mDone = 0; mX = 0; mY = 0; mCol = 0;
      return;
    end
    idle = !mBusy;
    if (idle && dr) begin
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          pixQ.push_back('{1'b1, 1'b0, mPosX + c, mPosY + r, er ? 0 : COL});
      pixQ.push_back('{1'b0, 1'b1, 0, 0, 0});
    end
    if (idle && ft) begin
      if (ml && !mr) mPosX = (mPosX - STEP < XMIN) ? XMIN : mPosX - STEP;
      if (mr && !ml) mPosX = (mPosX + STEP > XMAX) ? XMAX : mPosX + STEP;
      if (mu && !md) mPosY = (mPosY - STEP < YMIN) ? YMIN : mPosY - STEP;
      if (md && !mu) mPosY = (mPosY + STEP > YMAX) ? YMAX : mPosY + STEP;
    end
    if (pixQ.size() > 0) begin
      e = pixQ.pop_front();
      mBusy = 1; mPlot = e.plot; mDone = e.done;
      if (e.plot) begin
        mX = e.x; mY = e.y; mCol = e.col;
      end
    end else begin
      mBusy = 0; mPlot = 0; mDone = 0;
    end
  endtask

  task automatic applyStimulus(input bit rn, input bit ft, input bit mu, input bit md,
                               input bit ml, input bit mr, input bit dr, input bit er);
    reset_n = rn; frame_tick = ft; move_up = mu; move_down = md;
    move_left = ml; move_right = mr; draw_req = dr; erase = er;
    @(posedge clk);
    modelEdge(rn, ft, mu, md, ml, mr, dr, er);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".busy"}, 32'(busy), 32'(mBusy));
    checkVal({tag, ".plot"}, 32'(plot), 32'(mPlot));
    checkVal({tag, ".done"}, 32'(done), 32'(mDone));
    checkVal({tag, ".x_out"}, 32'(x_out), mX);
    checkVal({tag, ".y_out"}, 32'(y_out), mY);
    checkVal({tag, ".colour"}, 32'(colour_out), mCol);
    checkVal({tag, ".pos_x"}, 32'(pos_x), mPosX);
    checkVal({tag, ".pos_y"}, 32'(pos_y), mPosY);
  endtask

  initial begin
    $display("[TB] start");

    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("reset");
      checkVal("resetPosX", 32'(pos_x), 155);
      checkVal("resetPosY", 32'(pos_y), 0);
      checkVal("resetPlot", 32'(plot), 0);
    end
    checkVal("step4ResetX", 32'(posX2), 2);
    checkVal("step4ResetY", 32'(posY2), 114);

    tick2 = 1'b1; down2 = 1'b1; left2 = 1'b1;
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("release");
    checkVal("step4ClampX", 32'(posX2), 0);
    checkVal("step4ClampY", 32'(posY2), 116);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkVal("step4HoldX", 32'(posX2), 0);
    checkVal("step4HoldY", 32'(posY2), 116);
    tick2 = 1'b0; down2 = 1'b0; left2 = 1'b0;

    applyStimulus(1, 1, 1, 0, 0, 0, 0, 0);
    checkOutput("upAtMin");
    checkVal("upAtMinY", 32'(pos_y), 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 0, 1, 0, 0, 0, 0);
      checkOutput("downTick");
    end
    checkVal("down3Y", 32'(pos_y), 3);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, 0, 1, 0, 0, 0, 0);
      checkOutput("downNoTick");
    end
    checkVal("noTickY", 32'(pos_y), 3);
    applyStimulus(1, 1, 1, 1, 0, 0, 0, 0);
    checkOutput("upDown");
    checkVal("upDownY", 32'(pos_y), 3);

    applyStimulus(1, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("draw0");
    checkVal("draw0X", 32'(x_out), 155);
    checkVal("draw0Y", 32'(y_out), 3);
    checkVal("draw0Col", 32'(colour_out), 7);
    for (int k = 1; k < W * H; k++) begin
      applyStimulus(1, 1, 0, 1, 0, 0, 1, 0);
      checkOutput("drawPix");
      checkVal("drawPixX", 32'(x_out), 155 + (k % 2));
      checkVal("drawPixY", 32'(y_out), 3 + (k / 2));
    end
    applyStimulus(1, 1, 0, 1, 0, 0, 1, 0);
    checkOutput("drawDone");
    checkVal("drawDonePulse", 32'(done), 1);
    checkVal("drawDonePlot", 32'(plot), 0);
    applyStimulus(1, 1, 0, 1, 0, 0, 1, 0);
    checkOutput("drawIdle");
    checkVal("drawIdleBusy", 32'(busy), 0);
    checkVal("frozenY", 32'(pos_y), 3);

    applyStimulus(1, 1, 0, 1, 0, 0, 1, 1);
    checkOutput("erase0");
    checkVal("erase0Y", 32'(y_out), 3);
    checkVal("erase0Col", 32'(colour_out), 0);
    checkVal("eraseMoveY", 32'(pos_y), 4);
    for (int k = 0; k < W * H + 1; k++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("erasePass");
    end
    checkVal("eraseEndBusy", 32'(busy), 0);

    applyStimulus(1, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("abortPix0");
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("abortPix");
    end
    checkVal("abortThirdY", 32'(y_out), 5);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("abortReset");
    checkVal("abortPlot", 32'(plot), 0);
    checkVal("abortBusy", 32'(busy), 0);
    checkVal("abortPosX", 32'(pos_x), 155);
    checkVal("abortPosY", 32'(pos_y), 0);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("afterAbort");
      checkVal("afterAbortDone", 32'(done), 0);
    end

    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, 1, 0, 0, 0, 1, 0, 0);
      checkOutput("rightTick");
    end
    checkVal("rightClampX", 32'(pos_x), 158);

    for (int k = 0; k < 600; k++) begin
      applyStimulus($urandom_range(0, 39) != 0,
                    $urandom_range(0, 2) == 0,
                    1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    $urandom_range(0, 3) == 0,
                    1'($urandom));
      checkOutput("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
